bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Arbitrates the shared Pokémon Mini system bus between the S1C88 CPU, the PRC (LCD/sprite renderer) and a debug/DMA master. The CPU owns the bus by default. A secondary master takes the bus only through the CPU's bus_request/bus_ack handshake, which the CPU honours at an instruction boundary. The block sits in the top-level between the masters and the register/memory decode logic, and replaces the ad-hoc owner mux.

## Interface
Parameters:
- MAX_GRANT_CYCLES, 1024 — maximum consecutive cycles a secondary master may hold the bus. Only used with ARB_STARVE_LIMIT_EN.
- CNT_W, 11 — width of the grant counter; must satisfy 2^CNT_W > MAX_GRANT_CYCLES.

Ports:
- clk  in  1  system clock; all state on posedge.
- reset  in  1  synchronous, active-high.
- cpu_bus_request  out  1  to the CPU; asks it to release the bus.
- cpu_bus_ack  in  1  from the CPU; high while the CPU has released the bus.
- cpu_address / cpu_data / cpu_read / cpu_write / cpu_bus_status  in  24/8/1/1/2  CPU bus signals.
- prc_request  in  1  PRC wants the bus.
- prc_grant  out  1  PRC owns the bus.
- prc_address / prc_data / prc_read / prc_write / prc_bus_status  in  24/8/1/1/2  PRC bus signals.
- dbg_request  in  1  debug master wants the bus.
- dbg_grant  out  1  debug master owns the bus.
- dbg_address / dbg_data / dbg_read / dbg_write / dbg_bus_status  in  24/8/1/1/2  debug bus signals.
- address_out / data_out / read / write / bus_status  out  24/8/1/1/2  muxed system bus.
- owner  out  2  current owner: 0 = CPU, 1 = PRC, 2 = DBG, 3 = NONE.

## Operation
- States:
  - IDLE: owner CPU.
  - REQ: owner CPU; cpu_bus_request high.
  - GRANT_PRC: owner PRC.
  - GRANT_DBG: owner DBG.
  - SWITCH: owner NONE.
  - RELEASE: owner NONE; cpu_bus_request low.
- IDLE → REQ when prc_request or dbg_request is high.
- REQ: hold cpu_bus_request high until cpu_bus_ack is sampled high. Then select the master:
  - PRC beats DBG, unless the prefer_dbg flag is set.
  - If no request remains (requester withdrew), go to RELEASE.
- GRANT_x: grant_x stays high while request_x stays high.
  - request_x low and the other master requesting → SWITCH, then GRANT_other.
  - request_x low and no other request → RELEASE.
- RELEASE → IDLE when cpu_bus_ack is sampled low.
- Bus mux is combinational from the registered owner:
  - owner CPU/PRC/DBG passes through that master's signals.
  - owner NONE drives read=0, write=0, bus_status=2'b00, address_out=0, data_out=0.
- Grant outputs are registered and decoded from state. They are never high simultaneously.
- Reset: state IDLE; cpu_bus_request=0; prc_grant=0; dbg_grant=0; owner=0; counter=0; prefer_dbg=0.
- Reset mid-grant: the next state is IDLE regardless of cpu_bus_ack or requests.

## Timing
- Request seen in IDLE at edge N → cpu_bus_request high after edge N.
- cpu_bus_ack sampled high at edge M → grant high and owner switched after edge M.
- Request drop sampled at edge K → grant low after edge K.
  - Handover adds exactly one SWITCH cycle before the other master's grant.
  - Release waits at least one cycle in RELEASE.
- Simultaneous prc_request and dbg_request in IDLE/REQ: the priority rule decides. The loser stays pending and is served via SWITCH.
- Request asserted during RELEASE: ignored until IDLE, then re-arbitrated next cycle.
- cpu_bus_ack dropping during GRANT_x (protocol violation): go to RELEASE immediately and drop the grant.

## Configuration
- ARB_STARVE_LIMIT_EN defined:
  - The counter increments each cycle in GRANT_PRC/GRANT_DBG and clears on entering any other state.
  - When the count reaches MAX_GRANT_CYCLES-1, the next state is RELEASE even if the request is still high, so the CPU runs again.
  - After a forced release of PRC, prefer_dbg is set. It clears when DBG is granted.
- ARB_STARVE_LIMIT_EN undefined:
  - No counter and no forced release.
  - prefer_dbg is tied to 0, so fixed PRC priority applies.

## Test plan
- PRC request, CPU acks 3 cycles later:
  - cpu_bus_request high 1 cycle after the request.
  - prc_grant and owner=1 one cycle after the ack.
  - address_out equals prc_address.
- PRC and DBG request together:
  - PRC granted first.
  - PRC drops → owner=3 for 1 cycle → dbg_grant high, owner=2.
- DBG drops request, no other pending:
  - dbg_grant low and cpu_bus_request low next cycle.
  - owner=3 until cpu_bus_ack falls, then owner=0.
- reset asserted during GRANT_PRC:
  - Next cycle all grants=0, cpu_bus_request=0, owner=0.
- With ARB_STARVE_LIMIT_EN, MAX_GRANT_CYCLES=8, PRC holding the request:
  - prc_grant is high for exactly 8 cycles, then forced RELEASE.
  - On the next arbitration with both requesting, DBG wins.
- cpu_bus_ack drops during GRANT_DBG:
  - dbg_grant low next cycle; owner=3; state RELEASE.

Source files
------------

// File: rtl/bus_arbiter.sv
// Shared system bus arbiter: CPU owns the bus by default; PRC and debug masters get it via the CPU request/ack handshake.
// Optional ARB_STARVE_LIMIT_EN caps a secondary master's tenure at MAX_GRANT_CYCLES and then favours DBG once.
module bus_arbiter #(
  parameter int MAX_GRANT_CYCLES = 1024,
  parameter int CNT_W            = 11
) (
  input  logic        clk,
  input  logic        reset,
  output logic        cpu_bus_request,
  input  logic        cpu_bus_ack,
  input  logic [23:0] cpu_address,
  input  logic [7:0]  cpu_data,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [1:0]  cpu_bus_status,
  input  logic        prc_request,
  output logic        prc_grant,
  input  logic [23:0] prc_address,
  input  logic [7:0]  prc_data,
  input  logic        prc_read,
  input  logic        prc_write,
  input  logic [1:0]  prc_bus_status,
  input  logic        dbg_request,
  output logic        dbg_grant,
  input  logic [23:0] dbg_address,
  input  logic [7:0]  dbg_data,
  input  logic        dbg_read,
  input  logic        dbg_write,
  input  logic [1:0]  dbg_bus_status,
  output logic [23:0] address_out,
  output logic [7:0]  data_out,
  output logic        read,
  output logic        write,
  output logic [1:0]  bus_status,
  output logic [1:0]  owner
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_GRANT_PRC, S_GRANT_DBG, S_SWITCH, S_RELEASE
  } state_t;

  if (2 ** CNT_W <= MAX_GRANT_CYCLES) begin : g_bad_cfg
    $error("bus_arbiter: CNT_W too narrow for MAX_GRANT_CYCLES");
  end

  state_t      state_reg, state_next;
  logic        target_dbg_reg, target_dbg_next;
  logic        prefer_dbg;
  logic        limit_hit;
  logic [1:0]  owner_reg;
  logic        cpu_bus_request_reg, prc_grant_reg, dbg_grant_reg;

`ifdef ARB_STARVE_LIMIT_EN
  logic [CNT_W-1:0] cnt_reg;
  logic             prefer_dbg_reg;
  logic             force_prc;

  assign limit_hit  = (cnt_reg == CNT_W'(MAX_GRANT_CYCLES - 1));
  assign force_prc  = (state_reg == S_GRANT_PRC) && cpu_bus_ack && limit_hit;
  assign prefer_dbg = prefer_dbg_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg        <= '0;
      prefer_dbg_reg <= 1'b0;
    end else begin
      // Counter runs only while staying in the same grant state.
      if ((state_reg == S_GRANT_PRC || state_reg == S_GRANT_DBG) && state_next == state_reg)
        cnt_reg <= cnt_reg + 1'b1;
      else
        cnt_reg <= '0;
      if (state_next == S_GRANT_DBG && state_reg != S_GRANT_DBG)
        prefer_dbg_reg <= 1'b0;
      else if (force_prc)
        prefer_dbg_reg <= 1'b1;
    end
  end
`else
  assign limit_hit  = 1'b0;
  assign prefer_dbg = 1'b0;
`endif

  always_comb begin
    state_next      = state_reg;
    target_dbg_next = target_dbg_reg;
    case (state_reg)
      S_IDLE: begin
        if (prc_request || dbg_request) state_next = S_REQ;
      end
      S_REQ: begin
        if (cpu_bus_ack) begin
          if (prc_request && !(dbg_request && prefer_dbg)) state_next = S_GRANT_PRC;
          else if (dbg_request)                            state_next = S_GRANT_DBG;
          else                                             state_next = S_RELEASE;
        end
      end
      S_GRANT_PRC: begin
        if (!cpu_bus_ack || limit_hit) state_next = S_RELEASE;
        else if (!prc_request) begin
          if (dbg_request) begin
            state_next      = S_SWITCH;
            target_dbg_next = 1'b1;
          end else state_next = S_RELEASE;
        end
      end
      S_GRANT_DBG: begin
        if (!cpu_bus_ack || limit_hit) state_next = S_RELEASE;
        else if (!dbg_request) begin
          if (prc_request) begin
            state_next      = S_SWITCH;
            target_dbg_next = 1'b0;
          end else state_next = S_RELEASE;
        end
      end
      S_SWITCH: begin
        // The pending master may have withdrawn during the turnaround cycle.
        if (!cpu_bus_ack)                      state_next = S_RELEASE;
        else if (target_dbg_reg && dbg_request) state_next = S_GRANT_DBG;
        else if (!target_dbg_reg && prc_request) state_next = S_GRANT_PRC;
        else                                    state_next = S_RELEASE;
      end
      S_RELEASE: begin
        if (!cpu_bus_ack) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg           <= S_IDLE;
      target_dbg_reg      <= 1'b0;
      owner_reg           <= 2'd0;
      cpu_bus_request_reg <= 1'b0;
      prc_grant_reg       <= 1'b0;
      dbg_grant_reg       <= 1'b0;
    end else begin
      state_reg           <= state_next;
      target_dbg_reg      <= target_dbg_next;
      prc_grant_reg       <= (state_next == S_GRANT_PRC);
      dbg_grant_reg       <= (state_next == S_GRANT_DBG);
      cpu_bus_request_reg <= (state_next == S_REQ) || (state_next == S_GRANT_PRC) ||
                             (state_next == S_GRANT_DBG) || (state_next == S_SWITCH);
      case (state_next)
        S_IDLE, S_REQ: owner_reg <= 2'd0;
        S_GRANT_PRC:   owner_reg <= 2'd1;
        S_GRANT_DBG:   owner_reg <= 2'd2;
        default:       owner_reg <= 2'd3;
      endcase
    end
  end

  assign owner           = owner_reg;
  assign cpu_bus_request = cpu_bus_request_reg;
  assign prc_grant       = prc_grant_reg;
  assign dbg_grant       = dbg_grant_reg;

  always_comb begin
    address_out = '0;
    data_out    = '0;
    read        = 1'b0;
    write       = 1'b0;
    bus_status  = 2'b00;
    case (owner_reg)
      2'd0: begin
        address_out = cpu_address; data_out = cpu_data;
        read = cpu_read; write = cpu_write; bus_status = cpu_bus_status;
      end
      2'd1: begin
        address_out = prc_address; data_out = prc_data;
        read = prc_read; write = prc_write; bus_status = prc_bus_status;
      end
      2'd2: begin
        address_out = dbg_address; data_out = dbg_data;
        read = dbg_read; write = dbg_write; bus_status = dbg_bus_status;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: a reference model predicts ownership each cycle, a monitor compares at negedge.
module tb_bus_arbiter;
  localparam int MAX = 8;
  localparam int CW  = 4;
`ifdef ARB_STARVE_LIMIT_EN
  localparam bit LIMIT_ON = 1'b1;
`else
  localparam bit LIMIT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_bus_request, cpu_bus_ack;
  logic [23:0] cpu_address, prc_address, dbg_address, address_out;
  logic [7:0]  cpu_data, prc_data, dbg_data, data_out;
  logic        cpu_read, cpu_write, prc_read, prc_write, dbg_read, dbg_write, read, write;
  logic [1:0]  cpu_bus_status, prc_bus_status, dbg_bus_status, bus_status, owner;
  logic        prc_request, prc_grant, dbg_request, dbg_grant;

  always #5 clk = ~clk;

  bus_arbiter #(.MAX_GRANT_CYCLES(MAX), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .cpu_bus_request(cpu_bus_request), .cpu_bus_ack(cpu_bus_ack),
    .cpu_address(cpu_address), .cpu_data(cpu_data), .cpu_read(cpu_read),
    .cpu_write(cpu_write), .cpu_bus_status(cpu_bus_status),
    .prc_request(prc_request), .prc_grant(prc_grant),
    .prc_address(prc_address), .prc_data(prc_data), .prc_read(prc_read),
    .prc_write(prc_write), .prc_bus_status(prc_bus_status),
    .dbg_request(dbg_request), .dbg_grant(dbg_grant),
    .dbg_address(dbg_address), .dbg_data(dbg_data), .dbg_read(dbg_read),
    .dbg_write(dbg_write), .dbg_bus_status(dbg_bus_status),
    .address_out(address_out), .data_out(data_out), .read(read), .write(write),
    .bus_status(bus_status), .owner(owner)
  );

  typedef struct {
    logic [1:0] owner;
    logic       req;
    logic       pg;
    logic       dg;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Model state is the observable bus situation: who holds it and whether the CPU is being asked.
  int m_owner = 0;
  int m_target = 0;
  int m_cnt = 0;
  bit m_req = 1'b0;
  bit m_prefer = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic give(input int who);
    m_owner = who;
    m_cnt   = 0;
    if (who == 2) m_prefer = 1'b0;
  endtask

  task automatic let_go();
    m_owner = 3;
    m_req   = 1'b0;
  endtask

  task automatic model_step();
    bit mine, other;
    if (reset) begin
      m_owner = 0; m_req = 1'b0; m_cnt = 0; m_prefer = 1'b0;
    end else if (m_owner == 0 && !m_req) begin
      if (prc_request || dbg_request) m_req = 1'b1;
    end else if (m_owner == 0) begin
      if (cpu_bus_ack) begin
        if (prc_request && !(dbg_request && m_prefer)) give(1);
        else if (dbg_request)                          give(2);
        else                                           let_go();
      end
    end else if (m_owner == 1 || m_owner == 2) begin
      mine  = (m_owner == 1) ? prc_request : dbg_request;
      other = (m_owner == 1) ? dbg_request : prc_request;
      if (!cpu_bus_ack) let_go();
      else if (LIMIT_ON && m_cnt == MAX - 1) begin
        if (m_owner == 1) m_prefer = 1'b1;
        let_go();
      end else if (!mine) begin
        if (other) begin
          m_target = 3 - m_owner;
          m_owner  = 3;
        end else let_go();
      end else m_cnt++;
    end else if (m_req) begin
      if (!cpu_bus_ack) let_go();
      else if ((m_target == 1) ? prc_request : dbg_request) give(m_target);
      else let_go();
    end else begin
      if (!cpu_bus_ack) m_owner = 0;
    end
  endtask

  task automatic rand_bus();
    cpu_address = 24'($urandom); cpu_data = 8'($urandom);
    cpu_read = 1'($urandom); cpu_write = 1'($urandom); cpu_bus_status = 2'($urandom);
    prc_address = 24'($urandom); prc_data = 8'($urandom);
    prc_read = 1'($urandom); prc_write = 1'($urandom); prc_bus_status = 2'($urandom);
    dbg_address = 24'($urandom); dbg_data = 8'($urandom);
    dbg_read = 1'($urandom); dbg_write = 1'($urandom); dbg_bus_status = 2'($urandom);
  endtask

  task automatic cycles(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      model_step();
      e.owner = 2'(m_owner);
      e.req   = m_req;
      e.pg    = (m_owner == 1);
      e.dg    = (m_owner == 2);
      q.push_back(e);
      rand_bus();
    end
  endtask

  initial begin : monitor
    exp_t e;
    logic [35:0] exp_bus;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        case (e.owner)
          2'd0: exp_bus = {cpu_address, cpu_data, cpu_read, cpu_write, cpu_bus_status};
          2'd1: exp_bus = {prc_address, prc_data, prc_read, prc_write, prc_bus_status};
          2'd2: exp_bus = {dbg_address, dbg_data, dbg_read, dbg_write, dbg_bus_status};
          default: exp_bus = '0;
        endcase
        chk("owner", 64'(owner), 64'(e.owner));
        chk("cpu_bus_request", 64'(cpu_bus_request), 64'(e.req));
        chk("prc_grant", 64'(prc_grant), 64'(e.pg));
        chk("dbg_grant", 64'(dbg_grant), 64'(e.dg));
        chk("bus_mux", 64'({address_out, data_out, read, write, bus_status}), 64'(exp_bus));
      end
    end
  end

  initial begin
    reset = 1'b1; prc_request = 1'b0; dbg_request = 1'b0; cpu_bus_ack = 1'b0;
    rand_bus();
    cycles(2);
    reset = 1'b0;
    // PRC request, CPU acks three cycles later, PRC then releases
    prc_request = 1'b1; cycles(3);
    cpu_bus_ack = 1'b1; cycles(3);
    prc_request = 1'b0; cycles(1);
    cpu_bus_ack = 1'b0; cycles(2);
    // Both request: PRC first, handover through one SWITCH cycle to DBG, DBG releases
    prc_request = 1'b1; dbg_request = 1'b1; cycles(2);
    cpu_bus_ack = 1'b1; cycles(3);
    prc_request = 1'b0; cycles(3);
    dbg_request = 1'b0; cycles(2);
    cpu_bus_ack = 1'b0; cycles(2);
    // CPU ack drops while DBG holds the bus
    dbg_request = 1'b1; cycles(2);
    cpu_bus_ack = 1'b1; cycles(3);
    cpu_bus_ack = 1'b0; cycles(2);
    dbg_request = 1'b0; cycles(2);
    // Reset in the middle of a PRC grant
    prc_request = 1'b1; cycles(2);
    cpu_bus_ack = 1'b1; cycles(2);
    reset = 1'b1; cycles(1);
    reset = 1'b0; prc_request = 1'b0; cpu_bus_ack = 1'b0; cycles(3);
    // PRC holds its request past the tenure limit, then both compete
    prc_request = 1'b1; cycles(1);
    cpu_bus_ack = 1'b1; cycles(12);
    cpu_bus_ack = 1'b0; dbg_request = 1'b1; cycles(3);
    cpu_bus_ack = 1'b1; cycles(4);
    prc_request = 1'b0; dbg_request = 1'b0; cycles(2);
    cpu_bus_ack = 1'b0; cycles(3);
    // Randomized traffic with a CPU that acks late and occasionally misbehaves
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) prc_request = ~prc_request;
      if ($urandom_range(0, 7) == 0) dbg_request = ~dbg_request;
      if (cpu_bus_request && !cpu_bus_ack)       cpu_bus_ack = ($urandom_range(0, 2) == 0);
      else if (!cpu_bus_request && cpu_bus_ack)  cpu_bus_ack = ($urandom_range(0, 1) == 0);
      else if (cpu_bus_request && cpu_bus_ack && $urandom_range(0, 99) == 0) cpu_bus_ack = 1'b0;
      reset = ($urandom_range(0, 199) == 0);
      cycles(1);
    end
    reset = 1'b0; prc_request = 1'b0; dbg_request = 1'b0; cpu_bus_ack = 1'b0;
    cycles(3);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
